// File: rtl/imem_loader.sv
// imem_loader: byte-stream program loader for the 4 KB instruction memory.
// Takes a 16-bit big-endian word count header, then assembles big-endian
// 32-bit words and writes them to consecutive IMem word addresses. The CPU
// is held in reset until the full image has been written.
module imem_loader #(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned MAX_WORDS = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  input  logic              reload,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [31:0]       wdata,
  output logic [15:0]       words_loaded,
  output logic              done,
  output logic              error,
  output logic              cpu_rst_n
);

  typedef enum logic [2:0] {
    S_HDR_HI,
    S_HDR_LO,
    S_DATA,
    S_DONE,
    S_ERR
  } state_t;

  state_t              state_q, state_d;
  logic [15:0]         n_q, n_d;
  logic [23:0]         sh_q, sh_d;
  logic [1:0]          idx_q, idx_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [15:0]         wl_q, wl_d;

  logic                xfer;
  logic [15:0]         n_full;
  logic                image_written;

  assign xfer          = in_valid & in_ready;
  assign n_full        = {n_q[15:8], in_data};
  // The last word's write pulse is the cycle in which the count reaches N.
  assign image_written = we_q && (wl_q == n_q);

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_HDR_HI;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_HDR_HI: begin
        if (xfer) state_d = S_HDR_LO;
      end
      S_HDR_LO: begin
        if (xfer) begin
          if (n_full == 16'd0) begin
            state_d = S_DONE;
          end else if ({16'd0, n_full} > MAX_WORDS) begin
            state_d = S_ERR;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (image_written) state_d = S_DONE;
      end
      S_DONE, S_ERR: begin
        if (reload) state_d = S_HDR_HI;
      end
      default: state_d = S_HDR_HI;
    endcase
  end

  // FSM outputs decoded from the current state
  always_comb begin
    in_ready  = 1'b0;
    done      = 1'b0;
    error     = 1'b0;
    cpu_rst_n = 1'b0;
    case (state_q)
      S_HDR_HI, S_HDR_LO, S_DATA: in_ready = 1'b1;
      S_DONE: begin
        done      = 1'b1;
        cpu_rst_n = 1'b1;
      end
      S_ERR:   error = 1'b1;
      default: in_ready = 1'b0;
    endcase
  end

  // Datapath next values: header capture, word assembly and write issue
  always_comb begin
    n_d     = n_q;
    sh_d    = sh_q;
    idx_d   = idx_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    wl_d    = wl_q;
    case (state_q)
      S_HDR_HI: begin
        if (xfer) n_d[15:8] = in_data;
      end
      S_HDR_LO: begin
        if (xfer) begin
          n_d   = n_full;
          idx_d = 2'd0;
          wl_d  = 16'd0;
        end
      end
      S_DATA: begin
        if (xfer) begin
          sh_d  = {sh_q[15:0], in_data};
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            we_d    = 1'b1;
            wdata_d = {sh_q, in_data};
            waddr_d = ADDR_W'(wl_q);
            wl_d    = wl_q + 16'd1;
          end
        end
      end
      S_DONE, S_ERR: begin
        if (reload) wl_d = 16'd0;
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_q     <= '0;
      sh_q    <= '0;
      idx_q   <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      wl_q    <= '0;
    end else begin
      n_q     <= n_d;
      sh_q    <= sh_d;
      idx_q   <= idx_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      wl_q    <= wl_d;
    end
  end

  assign we           = we_q;
  assign waddr        = waddr_q;
  assign wdata        = wdata_q;
  assign words_loaded = wl_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed, table-driven bench for imem_loader.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_ready;
  logic        reload = 1'b0;
  logic        we;
  logic [9:0]  waddr;
  logic [31:0] wdata;
  logic [15:0] words_loaded;
  logic        done;
  logic        error;
  logic        cpu_rst_n;

  int unsigned errors = 0;
  int unsigned checks = 0;

  logic [9:0]  qa[$];
  logic [31:0] qd[$];

  imem_loader #(.ADDR_W(10), .MAX_WORDS(1024)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .reload       (reload),
    .we           (we),
    .waddr        (waddr),
    .wdata        (wdata),
    .words_loaded (words_loaded),
    .done         (done),
    .error        (error),
    .cpu_rst_n    (cpu_rst_n)
  );

  always #5 clk = ~clk;

  // Write log: every we pulse seen 1 time unit after the rising edge
  always @(posedge clk) begin
    #1;
    if (we) begin
      qa.push_back(waddr);
      qd.push_back(wdata);
    end
  end

  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic        rl;
    logic        rdy;
    logic        we;
    logic [9:0]  wa;
    logic [31:0] wd;
    logic [15:0] wl;
    logic        dn;
    logic        er;
    logic        cr;
  } vec_t;

  function automatic vec_t row(input logic v, input logic [7:0] d, input logic rl,
                               input logic rdy, input logic w, input logic [9:0] wa,
                               input logic [31:0] wd, input logic [15:0] wl,
                               input logic dn, input logic er, input logic cr);
    vec_t r;
    r.v = v; r.d = d; r.rl = rl; r.rdy = rdy; r.we = w; r.wa = wa;
    r.wd = wd; r.wl = wl; r.dn = dn; r.er = er; r.cr = cr;
    return r;
  endfunction

  function automatic logic [63:0] outs();
    return {1'b0, in_ready, we, waddr, wdata, words_loaded, done, error, cpu_rst_n};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the byte was taken.
  task automatic send_byte(input logic [7:0] b, input int unsigned gap);
    int unsigned t = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: in_ready stayed %b, required 1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic pulse_reload();
    @(negedge clk);
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
  endtask

  vec_t tbl[23];
  logic [31:0] w1 = 32'h1234_5678;
  logic [31:0] w2 = 32'h9ABC_DEF0;
  logic [7:0]  img2[10] = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};

  initial begin
    // 2-word image back-to-back, extra byte after DONE, reload,
    // oversized header (1025) -> ERR, reload, reload ignored in HDR_HI, N=0.
    tbl[0]  = row(1, 8'h00, 0, 1, 0, 10'd0, 32'h0, 16'd0, 0, 0, 0);
    tbl[1]  = row(1, 8'h02, 0, 1, 0, 10'd0, 32'h0, 16'd0, 0, 0, 0);
    tbl[2]  = row(1, 8'h12, 0, 1, 0, 10'd0, 32'h0, 16'd0, 0, 0, 0);
    tbl[3]  = row(1, 8'h34, 0, 1, 0, 10'd0, 32'h0, 16'd0, 0, 0, 0);
    tbl[4]  = row(1, 8'h56, 0, 1, 0, 10'd0, 32'h0, 16'd0, 0, 0, 0);
    tbl[5]  = row(1, 8'h78, 0, 1, 0, 10'd0, 32'h0, 16'd0, 0, 0, 0);
    tbl[6]  = row(1, 8'h9A, 0, 1, 1, 10'd0, w1,    16'd1, 0, 0, 0);
    tbl[7]  = row(1, 8'hBC, 0, 1, 0, 10'd0, w1,    16'd1, 0, 0, 0);
    tbl[8]  = row(1, 8'hDE, 0, 1, 0, 10'd0, w1,    16'd1, 0, 0, 0);
    tbl[9]  = row(1, 8'hF0, 0, 1, 0, 10'd0, w1,    16'd1, 0, 0, 0);
    tbl[10] = row(0, 8'h00, 0, 1, 1, 10'd1, w2,    16'd2, 0, 0, 0);
    tbl[11] = row(1, 8'h55, 0, 0, 0, 10'd1, w2,    16'd2, 1, 0, 1);
    tbl[12] = row(0, 8'h00, 0, 0, 0, 10'd1, w2,    16'd2, 1, 0, 1);
    tbl[13] = row(0, 8'h00, 1, 0, 0, 10'd1, w2,    16'd2, 1, 0, 1);
    tbl[14] = row(1, 8'h04, 0, 1, 0, 10'd1, w2,    16'd0, 0, 0, 0);
    tbl[15] = row(1, 8'h01, 0, 1, 0, 10'd1, w2,    16'd0, 0, 0, 0);
    tbl[16] = row(1, 8'h00, 0, 0, 0, 10'd1, w2,    16'd0, 0, 1, 0);
    tbl[17] = row(0, 8'h00, 1, 0, 0, 10'd1, w2,    16'd0, 0, 1, 0);
    tbl[18] = row(1, 8'h00, 1, 1, 0, 10'd1, w2,    16'd0, 0, 0, 0);
    tbl[19] = row(1, 8'h00, 0, 1, 0, 10'd1, w2,    16'd0, 0, 0, 0);
    tbl[20] = row(0, 8'h00, 0, 0, 0, 10'd1, w2,    16'd0, 1, 0, 1);
    tbl[21] = row(0, 8'h00, 1, 0, 0, 10'd1, w2,    16'd0, 1, 0, 1);
    tbl[22] = row(0, 8'h00, 0, 1, 0, 10'd1, w2,    16'd0, 0, 0, 0);

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset_outputs", outs(), {1'b0, 1'b1, 1'b0, 10'd0, 32'h0, 16'd0, 1'b0, 1'b0, 1'b0});
    rst_n = 1'b1;

    for (int unsigned i = 0; i < 23; i++) begin
      @(negedge clk);
      in_valid = tbl[i].v;
      in_data  = tbl[i].d;
      reload   = tbl[i].rl;
      #1;
      chk($sformatf("table_row%0d", i), outs(),
          {1'b0, tbl[i].rdy, tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].wl,
           tbl[i].dn, tbl[i].er, tbl[i].cr});
    end
    @(negedge clk);
    in_valid = 1'b0;
    reload   = 1'b0;
    chk("table_write_count", 64'(qa.size()), 64'd2);

    // Same 2-word image with 3 idle cycles between bytes
    pulse_reload();
    qa.delete();
    qd.delete();
    for (int unsigned i = 0; i < 10; i++) send_byte(img2[i], 3);
    repeat (3) @(negedge clk);
    chk("gap_write_count", 64'(qa.size()), 64'd2);
    if (qa.size() >= 2) begin
      chk("gap_write0", {22'd0, qa[0], qd[0]}, {22'd0, 10'd0, w1});
      chk("gap_write1", {22'd0, qa[1], qd[1]}, {22'd0, 10'd1, w2});
    end
    chk("gap_final", {61'd0, done, cpu_rst_n, error}, {61'd0, 3'b110});
    chk("gap_words_loaded", 64'(words_loaded), 64'd2);

    // Async reset in the middle of a word
    pulse_reload();
    qa.delete();
    qd.delete();
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", outs(), {1'b0, 1'b1, 1'b0, 10'd0, 32'h0, 16'd0, 1'b0, 1'b0, 1'b0});
    @(negedge clk);
    rst_n = 1'b1;
    chk("async_reset_no_write", 64'(qa.size()), 64'd0);
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    send_byte(8'hCC, 0);
    send_byte(8'hDD, 0);
    repeat (3) @(negedge clk);
    chk("post_reset_write_count", 64'(qa.size()), 64'd1);
    if (qa.size() >= 1) chk("post_reset_write", {22'd0, qa[0], qd[0]}, {22'd0, 10'd0, 32'hAABB_CCDD});
    chk("post_reset_done", {62'd0, done, cpu_rst_n}, {62'd0, 2'b11});

    // Full 1024-word image (word i = i)
    pulse_reload();
    qa.delete();
    qd.delete();
    send_byte(8'h04, 0);
    send_byte(8'h00, 0);
    for (int unsigned i = 0; i < 1024; i++) begin
      logic [31:0] w;
      w = i;
      send_byte(w[31:24], 0);
      send_byte(w[23:16], 0);
      send_byte(w[15:8], 0);
      send_byte(w[7:0], 0);
    end
    repeat (3) @(negedge clk);
    chk("full_write_count", 64'(qa.size()), 64'd1024);
    if (qa.size() == 1024) begin
      int unsigned bad = 0;
      for (int unsigned i = 0; i < 1024; i++) begin
        logic [31:0] w;
        w = i;
        if (qa[i] !== w[9:0] || qd[i] !== w) bad++;
      end
      chk("full_all_words", 64'(bad), 64'd0);
      chk("full_last_write", {22'd0, qa[1023], qd[1023]}, {22'd0, 10'd1023, 32'h0000_03FF});
    end
    chk("full_final", {60'd0, done, cpu_rst_n, error, in_ready}, {60'd0, 4'b1100});
    chk("full_words_loaded", 64'(words_loaded), 64'd1024);

    // Bytes offered after DONE are not taken
    in_valid = 1'b1;
    in_data  = 8'h77;
    repeat (5) @(negedge clk);
    chk("after_done_ready", {63'd0, in_ready}, 64'd0);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("after_done_no_write", 64'(qa.size()), 64'd1024);
    chk("after_done_state", {46'd0, words_loaded, done, cpu_rst_n}, {46'd0, 16'd1024, 2'b11});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
